lcd_pix_serializer: RTL and testbench

LCD_PIX_SERIALIZER -- requirements
Module: lcd_pix_serializer

---
 rtl/lcd_pix_serializer_if.sv | 53 +++++
 rtl/lcd_pix_serializer.sv | 207 ++++++++++++++++++++
 tb/tb_lcd_pix_serializer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pix_serializer_if.sv
// ---------------------------------------------------------------------------
// lcd_pix_serializer_if
//   Pixel-pair input bus and single-pixel output stream of the LCD pixel
//   serializer.
//
//   Handshake: the input side has no backpressure. A pair is offered on every
//   cycle in_valid is high. The output side is strict valid/ready. A pixel
//   transfers on a rising edge where out_valid and out_ready are both high.
//   out_valid never depends on out_ready. While out_valid is high and no
//   transfer happens, out_r/g/b and the markers stay stable.
//
//   Signals
//     in_valid               pair present this cycle
//     in_r0/g0/b0            pixel 0 (first) of the pair
//     in_r1/g1/b1            pixel 1 (second) of the pair
//     out_ready              consumer accepts the presented pixel
//     out_valid              a pixel is presented
//     out_r/g/b              presented pixel
//     out_sof/eol/eof        frame markers, qualified by out_valid
//
//   Modports
//     master : the producer/consumer environment around the serializer
//     slave  : the serializer itself
// ---------------------------------------------------------------------------
interface lcd_pix_serializer_if #(
  parameter int IMG_PIX_W = 8
);
  logic                 in_valid;
  logic [IMG_PIX_W-1:0] in_r0;
  logic [IMG_PIX_W-1:0] in_g0;
  logic [IMG_PIX_W-1:0] in_b0;
  logic [IMG_PIX_W-1:0] in_r1;
  logic [IMG_PIX_W-1:0] in_g1;
  logic [IMG_PIX_W-1:0] in_b1;
  logic                 out_ready;
  logic                 out_valid;
  logic [IMG_PIX_W-1:0] out_r;
  logic [IMG_PIX_W-1:0] out_g;
  logic [IMG_PIX_W-1:0] out_b;
  logic                 out_sof;
  logic                 out_eol;
  logic                 out_eof;

  modport master (
    output in_valid, in_r0, in_g0, in_b0, in_r1, in_g1, in_b1, out_ready,
    input  out_valid, out_r, out_g, out_b, out_sof, out_eol, out_eof
  );

  modport slave (
    input  in_valid, in_r0, in_g0, in_b0, in_r1, in_g1, in_b1, out_ready,
    output out_valid, out_r, out_g, out_b, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/lcd_pix_serializer.sv
// ---------------------------------------------------------------------------
// lcd_pix_serializer
//   Buffers pixel pairs from the LCD drive stage in a small FIFO and emits
//   them one pixel per accepted cycle, with start-of-frame, end-of-line and
//   end-of-frame markers. Pairs that arrive while the FIFO is full and no pop
//   happens are dropped and raise a sticky overflow flag.
//
//   Parameters
//     IMG_PIX_W   bits per colour component
//     W_SIZE      width of the frame width/height configuration
//     FIFO_DEPTH  pair entries, power of two (>= 2)
//
//   Ports
//     HCLK        clock, rising edge
//     HRESET      asynchronous active-high reset
//     cfg_width   pixels per line (0 means 2^W_SIZE)
//     cfg_height  lines per frame (0 means 2^W_SIZE)
//     ovf_clr     clears ovf; a same-edge overflow wins
//     bus         pixel bus (slave modport)
//     frame_done  one-cycle pulse after the last pixel of a frame is accepted
//     ovf         sticky overflow flag
//     fifo_level  number of pairs stored
// ---------------------------------------------------------------------------
module lcd_pix_serializer #(
  parameter int IMG_PIX_W  = 8,
  parameter int W_SIZE     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [W_SIZE-1:0]             cfg_width,
  input  logic [W_SIZE-1:0]             cfg_height,
  input  logic                          ovf_clr,
  lcd_pix_serializer_if.slave           bus,
  output logic                          frame_done,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = 3 * IMG_PIX_W;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  // Each entry is {pixel0, pixel1}, each pixel {r, g, b}.
  logic [2*PW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_phase;
  logic [W_SIZE-1:0] r_x;
  logic [W_SIZE-1:0] r_y;
  logic [W_SIZE-1:0] r_width_s;
  logic [W_SIZE-1:0] r_height_s;
  logic              r_ovf;
  logic              r_frame_done;

  logic              w_valid;
  logic              w_full;
  logic              w_accept;
  logic              w_pop;
  logic              w_push;
  logic              w_ovf_evt;
  logic              w_sof;
  logic              w_eol;
  logic              w_eof;
  logic              w_frame_start;
  logic [W_SIZE-1:0] w_x_last;
  logic [W_SIZE-1:0] w_y_last;
  logic [2*PW-1:0]   w_in_pair;
  logic [2*PW-1:0]   w_head;
  logic [PW-1:0]     w_pix;

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  assign w_in_pair = {bus.in_r0, bus.in_g0, bus.in_b0,
                      bus.in_r1, bus.in_g1, bus.in_b1};
  assign w_valid   = (r_level != '0);
  assign w_full    = (r_level == FULL_LVL);
  assign w_accept  = w_valid & bus.out_ready;
  // The head pair leaves only once its second pixel is taken.
  assign w_pop     = w_accept & r_phase;
  // A full FIFO still takes a new pair when the head leaves on the same edge.
  assign w_push    = bus.in_valid & (~w_full | w_pop);
  assign w_ovf_evt = bus.in_valid & w_full & ~w_pop;

  // ---------------------------------------------------------------------
  // Frame position markers. A shadow value of 0 wraps to all-ones here,
  // which is exactly the 2^W_SIZE behaviour wanted for a zero setting.
  // ---------------------------------------------------------------------
  assign w_x_last      = r_width_s  - W_SIZE'(1);
  assign w_y_last      = r_height_s - W_SIZE'(1);
  assign w_sof         = (r_x == '0) && (r_y == '0);
  assign w_eol         = (r_x == w_x_last);
  assign w_eof         = w_eol && (r_y == w_y_last);
  // Idle at the origin: safe point to pick up a new geometry.
  assign w_frame_start = w_sof & ~w_valid;

  // ---------------------------------------------------------------------
  // Output path: head entry, pixel picked by phase. Everything is gated by
  // out_valid so an empty FIFO (including reset) presents all zeros.
  // ---------------------------------------------------------------------
  assign w_head = r_mem[r_rd_ptr];
  assign w_pix  = r_phase ? w_head[PW-1:0] : w_head[2*PW-1:PW];

  assign bus.out_valid = w_valid;
  assign bus.out_r     = w_valid ? w_pix[PW-1 -: IMG_PIX_W]          : '0;
  assign bus.out_g     = w_valid ? w_pix[2*IMG_PIX_W-1 -: IMG_PIX_W] : '0;
  assign bus.out_b     = w_valid ? w_pix[IMG_PIX_W-1:0]             : '0;
  assign bus.out_sof   = w_valid & w_sof;
  assign bus.out_eol   = w_valid & w_eol;
  assign bus.out_eof   = w_valid & w_eof;

  assign fifo_level = r_level;
  assign ovf        = r_ovf;
  assign frame_done = r_frame_done;

  // ---------------------------------------------------------------------
  // Storage array: no reset needed, entries are only visible through
  // r_level, which is reset.
  // ---------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_pair;
    end
  end

  // ---------------------------------------------------------------------
  // Pointers and level. Pointers wrap naturally since the depth is a
  // power of two.
  // ---------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Pixel phase and frame position. Phase tracks pixel position inside
  // the pair only, so odd line widths need no special case.
  // ---------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_phase <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else if (w_accept) begin
      r_phase <= ~r_phase;
      if (w_eof) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_eol) begin
        r_x <= '0;
        r_y <= r_y + W_SIZE'(1);
      end else begin
        r_x <= r_x + W_SIZE'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Geometry shadows: reloaded only while idle at the frame origin, so a
  // mid-frame configuration change applies from the next frame.
  // ---------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_width_s  <= '0;
      r_height_s <= '0;
    end else if (w_frame_start) begin
      r_width_s  <= cfg_width;
      r_height_s <= cfg_height;
    end
  end

  // ---------------------------------------------------------------------
  // Status flags
  // ---------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ovf        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
      r_frame_done <= w_accept & w_eof;
    end
  end

endmodule

// File: tb/tb_lcd_pix_serializer.sv
module tb_lcd_pix_serializer;

  localparam int PXW   = 8;
  localparam int WS    = 12;
  localparam int DEPTH = 4;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic [WS-1:0] cfg_width;
  logic [WS-1:0] cfg_height;
  logic          ovf_clr;
  logic          frame_done;
  logic          ovf;
  logic [2:0]    fifo_level;

  always #5 clk = ~clk;

  lcd_pix_serializer_if #(.IMG_PIX_W(PXW)) bus ();

  lcd_pix_serializer #(
    .IMG_PIX_W (PXW),
    .W_SIZE    (WS),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .HCLK      (clk),
    .HRESET    (rst),
    .cfg_width (cfg_width),
    .cfg_height(cfg_height),
    .ovf_clr   (ovf_clr),
    .bus       (bus),
    .frame_done(frame_done),
    .ovf       (ovf),
    .fifo_level(fifo_level)
  );

  int n_chk;
  int n_pass;

  // ---------------------------------------------------------------------
  // Reference model: a queue of pending pixels plus a linear pixel index
  // within the current frame. Pair occupancy is ceil(pixels/2).
  // Observation vector: [32] valid, [31:8] rgb, [7] sof, [6] eol, [5] eof,
  // [4] frame_done, [3] ovf, [2:0] level.
  // ---------------------------------------------------------------------
  logic [23:0]   pix_q[$];
  int            m_k;
  logic [WS-1:0] m_w;
  logic [WS-1:0] m_h;
  logic          m_ovf;
  logic          m_fd;
  logic [10:0]   acc_log[$];  // accepted pixels as seen: {r, sof, eol, eof}

  function automatic int eff(input logic [WS-1:0] v);
    return (v == '0) ? (1 << WS) : int'(v);
  endfunction

  function automatic logic [32:0] model_exp();
    logic [32:0] e;
    int w, h, x, y;
    w = eff(m_w);
    h = eff(m_h);
    x = m_k % w;
    y = m_k / w;
    e = '0;
    if (pix_q.size() != 0) begin
      e[32]   = 1'b1;
      e[31:8] = pix_q[0];
      e[7]    = (m_k == 0);
      e[6]    = (x == w - 1);
      e[5]    = (x == w - 1) && (y == h - 1);
    end
    e[4]   = m_fd;
    e[3]   = m_ovf;
    e[2:0] = 3'((pix_q.size() + 1) / 2);
    return e;
  endfunction

  function automatic logic [32:0] dut_obs();
    return {bus.out_valid, bus.out_r, bus.out_g, bus.out_b,
            bus.out_sof, bus.out_eol, bus.out_eof, frame_done, ovf, fifo_level};
  endfunction

  function automatic void model_reset();
    pix_q.delete();
    m_k   = 0;
    m_w   = '0;
    m_h   = '0;
    m_ovf = 1'b0;
    m_fd  = 1'b0;
  endfunction

  function automatic void model_edge(input logic v, input logic [47:0] pair,
                                     input logic rdy, input logic clr,
                                     input logic [WS-1:0] cw, input logic [WS-1:0] ch);
    int          sz;
    logic        vld, acc, pop, full, eof_now;
    logic [32:0] e;
    sz      = pix_q.size();
    vld     = (sz != 0);
    acc     = vld && rdy;
    pop     = acc && (sz % 2 == 1);
    full    = ((sz + 1) / 2) == DEPTH;
    e       = model_exp();
    eof_now = e[5];
    if (m_k == 0 && !vld) begin
      m_w = cw;
      m_h = ch;
    end
    m_fd = acc && eof_now;
    if (acc) begin
      void'(pix_q.pop_front());
      m_k = eof_now ? 0 : m_k + 1;
    end
    if (v && (!full || pop)) begin
      pix_q.push_back(pair[47:24]);
      pix_q.push_back(pair[23:0]);
    end
    if (v && full && !pop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endfunction

  function automatic logic [47:0] mk_pair(input int r0, input int r1);
    return {8'(r0), 8'($urandom), 8'($urandom), 8'(r1), 8'($urandom), 8'($urandom)};
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks. Each step starts and ends 1 time unit after a rising edge.
  // ---------------------------------------------------------------------
  task automatic step(input logic v, input logic [47:0] pair, input logic rdy,
                      input logic clr);
    bus.in_valid = v;
    {bus.in_r0, bus.in_g0, bus.in_b0, bus.in_r1, bus.in_g1, bus.in_b1} = pair;
    bus.out_ready = rdy;
    ovf_clr = clr;
    #1;
    if (bus.out_valid && rdy)
      acc_log.push_back({bus.out_r, bus.out_sof, bus.out_eol, bus.out_eof});
    @(posedge clk);
    if (!rst) model_edge(v, pair, rdy, clr, cfg_width, cfg_height);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    model_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    ovf_clr       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    bus.in_valid = 1'b1;
    {bus.in_r0, bus.in_g0, bus.in_b0, bus.in_r1, bus.in_g1, bus.in_b1} = mk_pair(5, 6);
    bus.out_ready = 1'b1;
    ovf_clr = 1'b0;
    cfg_width = 12'd4;
    cfg_height = 12'd2;
    #1;
    n_chk++;
    if (dut_obs() !== 33'd0) $display("FAIL reset_async got=%h exp=%h", dut_obs(), 33'd0);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (dut_obs() !== 33'd0) $display("FAIL reset_hold got=%h exp=%h", dut_obs(), 33'd0);
    else n_pass++;
    bus.in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int fd_at;
    logic [10:0] ex;
    cfg_width = 12'd4;
    cfg_height = 12'd2;
    do_reset();
    acc_log.delete();
    fd_at = -1;
    for (int i = 0; i < 12; i++) begin
      step(i < 4, mk_pair(2 * i + 1, 2 * i + 2), 1'b1, 1'b0);
      n_chk++;
      if (dut_obs() !== model_exp())
        $display("FAIL basic cyc=%0d got=%h exp=%h", i, dut_obs(), model_exp());
      else n_pass++;
      if (frame_done === 1'b1 && fd_at < 0) fd_at = i;
    end
    n_chk++;
    if (acc_log.size() != 8) $display("FAIL basic_count got=%0d exp=8", acc_log.size());
    else n_pass++;
    for (int j = 0; j < 8 && j < acc_log.size(); j++) begin
      ex = {8'(j + 1), j == 0, (j == 3) || (j == 7), j == 7};
      n_chk++;
      if (acc_log[j] !== ex) $display("FAIL basic_pix%0d got=%h exp=%h", j + 1, acc_log[j], ex);
      else n_pass++;
    end
    n_chk++;
    if (fd_at != 8 || ovf !== 1'b0)
      $display("FAIL basic_done got=%0d/%b exp=8/0", fd_at, ovf);
    else n_pass++;
  endtask

  task automatic test_overflow();
    cfg_width = 12'd4;
    cfg_height = 12'd2;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, mk_pair(2 * i + 1, 2 * i + 2), 1'b0, 1'b0);
      n_chk++;
      if (dut_obs() !== model_exp())
        $display("FAIL ovf_fill cyc=%0d got=%h exp=%h", i, dut_obs(), model_exp());
      else n_pass++;
    end
    n_chk++;
    if (fifo_level !== 3'd4 || ovf !== 1'b1)
      $display("FAIL ovf_sat got=%0d/%b exp=4/1", fifo_level, ovf);
    else n_pass++;
    acc_log.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 48'd0, 1'b1, 1'b0);
      n_chk++;
      if (dut_obs() !== model_exp())
        $display("FAIL ovf_drain cyc=%0d got=%h exp=%h", i, dut_obs(), model_exp());
      else n_pass++;
    end
    n_chk++;
    if (acc_log.size() != 8) $display("FAIL ovf_count got=%0d exp=8", acc_log.size());
    else n_pass++;
    for (int j = 0; j < 8 && j < acc_log.size(); j++) begin
      n_chk++;
      if (acc_log[j][10:3] !== 8'(j + 1))
        $display("FAIL ovf_order%0d got=%0d exp=%0d", j, acc_log[j][10:3], j + 1);
      else n_pass++;
    end
    step(1'b0, 48'd0, 1'b0, 1'b1);
    n_chk++;
    if (ovf !== 1'b0 || dut_obs() !== model_exp())
      $display("FAIL ovf_clr got=%h exp=%h", dut_obs(), model_exp());
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    cfg_width = 12'd4;
    cfg_height = 12'd2;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, mk_pair(2 * i + 1, 2 * i + 2), 1'b0, 1'b0);
    acc_log.delete();
    step(1'b0, 48'd0, 1'b1, 1'b0);
    n_chk++;
    if (dut_obs() !== model_exp()) $display("FAIL fpp_ph0 got=%h exp=%h", dut_obs(), model_exp());
    else n_pass++;
    step(1'b1, mk_pair(9, 10), 1'b1, 1'b0);
    n_chk++;
    if (fifo_level !== 3'd4 || ovf !== 1'b0)
      $display("FAIL fpp_level got=%0d/%b exp=4/0", fifo_level, ovf);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 48'd0, 1'b1, 1'b0);
      n_chk++;
      if (dut_obs() !== model_exp())
        $display("FAIL fpp_drain cyc=%0d got=%h exp=%h", i, dut_obs(), model_exp());
      else n_pass++;
    end
    n_chk++;
    if (acc_log.size() != 10) $display("FAIL fpp_count got=%0d exp=10", acc_log.size());
    else n_pass++;
    for (int j = 0; j < 10 && j < acc_log.size(); j++) begin
      n_chk++;
      if (acc_log[j][10:3] !== 8'(j + 1))
        $display("FAIL fpp_order%0d got=%0d exp=%0d", j, acc_log[j][10:3], j + 1);
      else n_pass++;
    end
  endtask

  task automatic test_odd_width();
    logic [10:0] ex;
    cfg_width = 12'd3;
    cfg_height = 12'd2;
    do_reset();
    acc_log.delete();
    for (int i = 0; i < 9; i++) begin
      step(i < 3, mk_pair(2 * i + 1, 2 * i + 2), 1'b1, 1'b0);
      n_chk++;
      if (dut_obs() !== model_exp())
        $display("FAIL odd cyc=%0d got=%h exp=%h", i, dut_obs(), model_exp());
      else n_pass++;
    end
    n_chk++;
    if (acc_log.size() != 6) $display("FAIL odd_count got=%0d exp=6", acc_log.size());
    else n_pass++;
    for (int j = 0; j < 6 && j < acc_log.size(); j++) begin
      ex = {8'(j + 1), j == 0, (j == 2) || (j == 5), j == 5};
      n_chk++;
      if (acc_log[j] !== ex) $display("FAIL odd_pix%0d got=%h exp=%h", j + 1, acc_log[j], ex);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] ex;
    cfg_width = 12'd4;
    cfg_height = 12'd2;
    do_reset();
    for (int i = 0; i < 6; i++) step(i < 4, mk_pair(2 * i + 1, 2 * i + 2), 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if (dut_obs() !== 33'd0) $display("FAIL rstmid_async got=%h exp=%h", dut_obs(), 33'd0);
    else n_pass++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, mk_pair(99, 98), 1'b1, 1'b0);
      n_chk++;
      if (dut_obs() !== 33'd0) $display("FAIL rstmid_hold cyc=%0d got=%h exp=%h", i, dut_obs(), 33'd0);
      else n_pass++;
    end
    rst = 1'b0;
    acc_log.delete();
    for (int i = 0; i < 4; i++) begin
      step(i == 0, mk_pair(11, 12), 1'b1, 1'b0);
      n_chk++;
      if (dut_obs() !== model_exp())
        $display("FAIL rstmid_new cyc=%0d got=%h exp=%h", i, dut_obs(), model_exp());
      else n_pass++;
    end
    ex = {8'd11, 1'b1, 1'b0, 1'b0};
    n_chk++;
    if (acc_log.size() == 0 || acc_log[0] !== ex)
      $display("FAIL rstmid_sof got=%h exp=%h", (acc_log.size() == 0) ? 11'h0 : acc_log[0], ex);
    else n_pass++;
  endtask

  task automatic test_cfg_change();
    logic [10:0] ex;
    int r;
    cfg_width = 12'd4;
    cfg_height = 12'd2;
    do_reset();
    acc_log.delete();
    for (int i = 0; i < 18; i++) begin
      if (i == 2) cfg_width = 12'd2;
      step((i < 4) || (i == 13) || (i == 14),
           (i < 4) ? mk_pair(2 * i + 1, 2 * i + 2) : mk_pair(2 * i - 5, 2 * i - 4),
           1'b1, 1'b0);
      n_chk++;
      if (dut_obs() !== model_exp())
        $display("FAIL cfg cyc=%0d got=%h exp=%h", i, dut_obs(), model_exp());
      else n_pass++;
    end
    n_chk++;
    if (acc_log.size() != 12) $display("FAIL cfg_count got=%0d exp=12", acc_log.size());
    else n_pass++;
    for (int j = 0; j < 12 && j < acc_log.size(); j++) begin
      r = (j < 8) ? j + 1 : j + 13;
      if (j < 8) ex = {8'(r), j == 0, (j == 3) || (j == 7), j == 7};
      else       ex = {8'(r), j == 8, (j == 9) || (j == 11), j == 11};
      n_chk++;
      if (acc_log[j] !== ex) $display("FAIL cfg_pix%0d got=%h exp=%h", j, acc_log[j], ex);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic v, rdy, clr;
    cfg_width = 12'($urandom_range(1, 5));
    cfg_height = 12'($urandom_range(1, 3));
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 25) begin
        cfg_width = 12'($urandom_range(1, 5));
        cfg_height = 12'($urandom_range(1, 3));
      end
      v   = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < 70);
      clr = ($urandom_range(0, 99) < 5);
      step(v, mk_pair($urandom_range(0, 255), $urandom_range(0, 255)), rdy, clr);
      n_chk++;
      if (dut_obs() !== model_exp())
        $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_obs(), model_exp());
      else n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------
  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_odd_width();
    test_reset_mid();
    test_cfg_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
